calc_key_entry: RTL

- Operand-entry stage directly upstream of the calculator ALU.
- Consumes decoded keypad codes and assembles two signed BCD operands with decimal-point positions plus an operation code.
- Pulses a compute strobe, then captures the combinational ALU result back as operand 0 for display and chaining.
- Also drives the value currently shown on the display.

---
 rtl/calc_key_entry_pkg.sv | 52 +++++
 rtl/calc_key_entry_if.sv | 43 ++++
 rtl/calc_key_entry_bcd_entry_reg.sv | 80 ++++++++
 rtl/calc_key_entry.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_key_entry_pkg.sv
// Shared key codes, operation encodings and state/command types for the key-entry stage.
package calc_key_entry_pkg;

  localparam int unsigned KEY_W = 5;
  localparam int unsigned DP_W  = 3;
  localparam int unsigned OP_W  = 3;

  localparam logic [KEY_W-1:0] KEY_DP   = 5'd10;
  localparam logic [KEY_W-1:0] KEY_SIGN = 5'd11;
  localparam logic [KEY_W-1:0] KEY_ADD  = 5'd12;
  localparam logic [KEY_W-1:0] KEY_SUB  = 5'd13;
  localparam logic [KEY_W-1:0] KEY_MUL  = 5'd14;
  localparam logic [KEY_W-1:0] KEY_DIV  = 5'd15;
  localparam logic [KEY_W-1:0] KEY_POW  = 5'd16;
  localparam logic [KEY_W-1:0] KEY_EQ   = 5'd17;
  localparam logic [KEY_W-1:0] KEY_CE   = 5'd18;
  localparam logic [KEY_W-1:0] KEY_CA   = 5'd19;

  // Operation encoding shared with the ALU (key_code - KEY_ADD)
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_POW = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    EVAL    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  // Edit commands applied to one operand register
  typedef enum logic [2:0] {
    ENT_NOP   = 3'd0,
    ENT_DIGIT = 3'd1,
    ENT_DP    = 3'd2,
    ENT_SIGN  = 3'd3,
    ENT_LOAD  = 3'd4
  } ent_cmd_e;

  // Request to an operand register: optional clear, then the command
  typedef struct packed {
    logic       clr;
    ent_cmd_e   cmd;
    logic [3:0] digit;
  } ent_req_t;

endpackage

// File: rtl/calc_key_entry_if.sv
// Key handshake, ALU result return and operand/display bus of the key-entry stage.
interface calc_key_entry_if
  import calc_key_entry_pkg::*;
#(
  parameter int unsigned DIGIT_NUM = 8
);
  localparam int unsigned VAL_W = DIGIT_NUM * 4;

  logic              key_valid;
  logic [KEY_W-1:0]  key_code;
  logic              key_ready;

  logic [VAL_W-1:0]  alu_result;
  logic              alu_result_sign;
  logic [DP_W-1:0]   alu_result_dp;

  logic [VAL_W-1:0]  operand0;
  logic              operand0_sign;
  logic [DP_W-1:0]   operand0_dp;
  logic [VAL_W-1:0]  operand1;
  logic              operand1_sign;
  logic [DP_W-1:0]   operand1_dp;
  logic [OP_W-1:0]   operation;
  logic              calc_start;

  logic [VAL_W-1:0]  disp_value;
  logic              disp_sign;
  logic [DP_W-1:0]   disp_dp;

  modport slave (
    input  key_valid, key_code, alu_result, alu_result_sign, alu_result_dp,
    output key_ready, operand0, operand0_sign, operand0_dp,
           operand1, operand1_sign, operand1_dp, operation, calc_start,
           disp_value, disp_sign, disp_dp
  );

  modport master (
    output key_valid, key_code, alu_result, alu_result_sign, alu_result_dp,
    input  key_ready, operand0, operand0_sign, operand0_dp,
           operand1, operand1_sign, operand1_dp, operation, calc_start,
           disp_value, disp_sign, disp_dp
  );
endinterface

// File: rtl/calc_key_entry_bcd_entry_reg.sv
// One signed BCD operand under entry: value, sign, dp position, dp_set flag and digit count.
module calc_key_entry_bcd_entry_reg
  import calc_key_entry_pkg::*;
#(
  parameter int unsigned DIGIT_NUM = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  ent_req_t                 req,
  input  logic [DIGIT_NUM*4-1:0]   load_value,
  input  logic                     load_sign,
  input  logic [DP_W-1:0]          load_dp,
  output logic [DIGIT_NUM*4-1:0]   value,
  output logic                     sign,
  output logic [DP_W-1:0]          dp
);

  localparam int unsigned VAL_W = DIGIT_NUM * 4;
  localparam int unsigned CNT_W = $clog2(DIGIT_NUM + 1);
  localparam logic [DP_W-1:0] DP_MAX = '1;

  logic [VAL_W-1:0] value_n;
  logic             sign_n;
  logic [DP_W-1:0]  dp_n;
  logic             dp_set_q, dp_set_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             full;
  logic             leading_zero;

  // Next operand: optional clear first, then apply the edit command
  always_comb begin
    value_n  = req.clr ? '0   : value;
    sign_n   = req.clr ? 1'b0 : sign;
    dp_n     = req.clr ? '0   : dp;
    dp_set_n = req.clr ? 1'b0 : dp_set_q;
    cnt_n    = req.clr ? '0   : cnt_q;

    full         = (cnt_n == CNT_W'(DIGIT_NUM)) || (dp_n == DP_MAX);
    leading_zero = (req.digit == 4'd0) && (value_n == '0) && !dp_set_n;

    case (req.cmd)
      ENT_DIGIT: begin
        if (!full && !leading_zero) begin
          value_n = {value_n[VAL_W-5:0], req.digit};
          cnt_n   = cnt_n + CNT_W'(1);
          if (dp_set_n) dp_n = dp_n + DP_W'(1);
        end
      end
      ENT_DP:   dp_set_n = 1'b1;
      ENT_SIGN: sign_n   = ~sign_n;
      ENT_LOAD: begin
        value_n  = load_value;
        sign_n   = load_sign;
        dp_n     = load_dp;
        dp_set_n = (load_dp != '0);
        // A captured result is never extended by typing; it is cleared first
        cnt_n    = CNT_W'(DIGIT_NUM);
      end
      default: ;
    endcase
  end

  // Operand state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value    <= '0;
      sign     <= 1'b0;
      dp       <= '0;
      dp_set_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      value    <= value_n;
      sign     <= sign_n;
      dp       <= dp_n;
      dp_set_q <= dp_set_n;
      cnt_q    <= cnt_n;
    end
  end

endmodule

// File: rtl/calc_key_entry.sv
// Calculator operand-entry stage: turns key codes into two BCD operands plus an operation,
// strobes the ALU and captures its result back into operand 0.
module calc_key_entry
  import calc_key_entry_pkg::*;
#(
  parameter int unsigned DIGIT_NUM = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  calc_key_entry_if.slave bus
);

  localparam int unsigned VAL_W = DIGIT_NUM * 4;

  state_e           state_q, state_n;
  op_e              operation_q, operation_n;
  op_e              pending_q, pending_n;
  logic             chain_q, chain_n;
  logic             key_ready_q;
  logic             calc_start_q;
  logic [VAL_W-1:0] disp_value_q;
  logic             disp_sign_q;
  logic [DP_W-1:0]  disp_dp_q;

  logic             accept;
  logic             is_digit, is_dp, is_sign, is_op, is_eq, is_ce, is_ca;
  ent_cmd_e         key_cmd;
  op_e              key_op;
  ent_req_t         req0, req1;

  logic [VAL_W-1:0] op0_value, op1_value;
  logic             op0_sign, op1_sign;
  logic [DP_W-1:0]  op0_dp, op1_dp;

  // Key decode
  assign accept   = bus.key_valid && key_ready_q;
  assign is_digit = (bus.key_code <= 5'd9);
  assign is_dp    = (bus.key_code == KEY_DP);
  assign is_sign  = (bus.key_code == KEY_SIGN);
  assign is_op    = (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_POW);
  assign is_eq    = (bus.key_code == KEY_EQ);
  assign is_ce    = (bus.key_code == KEY_CE);
  assign is_ca    = (bus.key_code == KEY_CA);
  assign key_cmd  = is_digit ? ENT_DIGIT : is_dp ? ENT_DP : is_sign ? ENT_SIGN : ENT_NOP;
  assign key_op   = op_e'(OP_W'(bus.key_code - KEY_ADD));

  // Next state and per-operand edit requests
  always_comb begin
    state_n     = state_q;
    operation_n = operation_q;
    pending_n   = pending_q;
    chain_n     = chain_q;
    req0.clr    = 1'b0;
    req0.cmd    = ENT_NOP;
    req0.digit  = bus.key_code[3:0];
    req1.clr    = 1'b0;
    req1.cmd    = ENT_NOP;
    req1.digit  = bus.key_code[3:0];

    if (state_q == EVAL) begin
      req0.cmd = ENT_LOAD;
      if (chain_q) begin
        operation_n = pending_q;
        state_n     = OP_WAIT;
      end else begin
        state_n     = SHOW;
      end
    end else if (accept) begin
      if (is_ca) begin
        req0.clr    = 1'b1;
        req1.clr    = 1'b1;
        state_n     = ENTER_A;
        operation_n = OP_ADD;
        pending_n   = OP_ADD;
        chain_n     = 1'b0;
      end else if (is_ce) begin
        if (state_q == ENTER_B) req1.clr = 1'b1;
        else                    req0.clr = 1'b1;
        if (state_q == SHOW) state_n = ENTER_A;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (is_op) begin
              operation_n = key_op;
              state_n     = OP_WAIT;
            end else begin
              req0.cmd = key_cmd;
            end
          end
          OP_WAIT: begin
            if (is_op) begin
              operation_n = key_op;
            end else if (is_digit || is_dp) begin
              req1.clr = 1'b1;
              req1.cmd = key_cmd;
              state_n  = ENTER_B;
            end else if (is_sign) begin
              req0.cmd = ENT_SIGN;
            end
          end
          ENTER_B: begin
            if (is_eq) begin
              chain_n = 1'b0;
              state_n = EVAL;
            end else if (is_op) begin
              chain_n   = 1'b1;
              pending_n = key_op;
              state_n   = EVAL;
            end else begin
              req1.cmd = key_cmd;
            end
          end
          SHOW: begin
            if (is_op) begin
              operation_n = key_op;
              state_n     = OP_WAIT;
            end else if (is_digit || is_dp) begin
              req0.clr = 1'b1;
              req0.cmd = key_cmd;
              state_n  = ENTER_A;
            end else if (is_sign) begin
              req0.cmd = ENT_SIGN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Operand 0: first entry, ALU result capture
  calc_key_entry_bcd_entry_reg #(.DIGIT_NUM(DIGIT_NUM)) u_op0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req0),
    .load_value (bus.alu_result),
    .load_sign  (bus.alu_result_sign),
    .load_dp    (bus.alu_result_dp),
    .value      (op0_value),
    .sign       (op0_sign),
    .dp         (op0_dp)
  );

  // Operand 1: second entry, never loaded
  calc_key_entry_bcd_entry_reg #(.DIGIT_NUM(DIGIT_NUM)) u_op1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req1),
    .load_value (bus.alu_result),
    .load_sign  (bus.alu_result_sign),
    .load_dp    (bus.alu_result_dp),
    .value      (op1_value),
    .sign       (op1_sign),
    .dp         (op1_dp)
  );

  // State, operation, strobe and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ENTER_A;
      operation_q  <= OP_ADD;
      pending_q    <= OP_ADD;
      chain_q      <= 1'b0;
      key_ready_q  <= 1'b1;
      calc_start_q <= 1'b0;
      disp_value_q <= '0;
      disp_sign_q  <= 1'b0;
      disp_dp_q    <= '0;
    end else begin
      state_q      <= state_n;
      operation_q  <= operation_n;
      pending_q    <= pending_n;
      chain_q      <= chain_n;
      key_ready_q  <= (state_n != EVAL);
      calc_start_q <= (state_n == EVAL);
      if (accept && is_ca && (state_q != EVAL)) begin
        disp_value_q <= '0;
        disp_sign_q  <= 1'b0;
        disp_dp_q    <= '0;
      end else if (state_q == ENTER_B) begin
        disp_value_q <= op1_value;
        disp_sign_q  <= op1_sign;
        disp_dp_q    <= op1_dp;
      end else begin
        disp_value_q <= op0_value;
        disp_sign_q  <= op0_sign;
        disp_dp_q    <= op0_dp;
      end
    end
  end

  assign bus.key_ready     = key_ready_q;
  assign bus.calc_start    = calc_start_q;
  assign bus.operation     = operation_q;
  assign bus.operand0      = op0_value;
  assign bus.operand0_sign = op0_sign;
  assign bus.operand0_dp   = op0_dp;
  assign bus.operand1      = op1_value;
  assign bus.operand1_sign = op1_sign;
  assign bus.operand1_dp   = op1_dp;
  assign bus.disp_value    = disp_value_q;
  assign bus.disp_sign     = disp_sign_q;
  assign bus.disp_dp       = disp_dp_q;

endmodule
